// File: rtl/demux_1to16_deser.sv
// 1-to-N word deserializer: steers a valid/ready word stream into an N-slot bank
// and presents the finished bank as one parallel frame on a second valid/ready port.
module demux_1to16_deser #(
    parameter int N     = 16,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0][WIDTH-1:0]      out_data,
    output logic [$clog2(N+1)-1:0]       out_count
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N-1:0][WIDTH-1:0] slots_q, slots_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept;
    logic                    frame_end;

    // in_ready_q is high exactly when the FSM sits in FILL, so this is the FILL-only accept.
    assign accept    = in_valid & in_ready_q;
    assign frame_end = (idx_q == IDX_W'(N - 1)) | in_last;

    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see earlier results;
        // NOTE: every _d is given its hold value first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        slots_d = slots_q;
        count_d = count_q;

        case (state_q)
            FILL: begin
                if (flush) begin
                    idx_d   = '0;
                    slots_d = '0;
                    count_d = '0;
                end else if (accept) begin
                    slots_d[idx_q] = in_data;
                    count_d        = CNT_W'(idx_q) + CNT_W'(1);
                    if (frame_end) begin
                        state_d = HOLD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                // Handoff and abort both return an empty bank to FILL.
                if (flush | out_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    slots_d = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            idx_q       <= '0;
            // NOTE: the slot bank is reset too; no word of an interrupted frame may stay visible.
            slots_q     <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all flops update together.
            state_q     <= state_d;
            idx_q       <= idx_d;
            slots_q     <= slots_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = slots_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_demux_1to16_deser.sv
// Scoreboard bench for demux_1to16_deser: a 16x4 instance and a 2x8 instance.
module tb_demux_1to16_deser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic             in_valid, in_ready, in_last, flush, out_valid, out_ready;
    logic [3:0]       in_data;
    logic [15:0][3:0] out_data;
    logic [4:0]       out_count;

    logic             b_in_valid, b_in_ready, b_in_last, b_flush, b_out_valid, b_out_ready;
    logic [7:0]       b_in_data;
    logic [1:0][7:0]  b_out_data;
    logic [1:0]       b_out_count;

    demux_1to16_deser #(.N(16), .WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    demux_1to16_deser #(.N(2), .WIDTH(8)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_count(b_out_count)
    );

    typedef struct {
        logic [63:0] data;
        int          count;
    } frame_t;

    frame_t exp_q[$];
    frame_t exp_b_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expected frame per handoff seen on each output port.
    always @(negedge clk) begin
        frame_t f;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_frame", 64'd1, 64'd0);
            end else begin
                f = exp_q.pop_front();
                check("sb_data", 64'(out_data), f.data);
                check("sb_count", 64'(out_count), 64'(f.count));
            end
        end
    end

    always @(negedge clk) begin
        frame_t f;
        if (b_out_valid && b_out_ready) begin
            if (exp_b_q.size() == 0) begin
                check("sb_b_unexpected_frame", 64'd1, 64'd0);
            end else begin
                f = exp_b_q.pop_front();
                check("sb_b_data", 64'(b_out_data), f.data);
                check("sb_b_count", 64'(b_out_count), 64'(f.count));
            end
        end
    end

    // All tasks start and end at posedge+1, the drive phase.
    task automatic send(input logic [3:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        check("fill_in_ready", 64'(in_ready), 64'd1);
        check("fill_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input logic [63:0] d, input int cnt);
        @(negedge clk);
        check("frame_valid", 64'(out_valid), 64'd1);
        check("frame_in_ready", 64'(in_ready), 64'd0);
        check("frame_count", 64'(out_count), 64'(cnt));
        check("frame_data", 64'(out_data), d);
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_count"}, 64'(out_count), 64'd0);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_empty("after_handoff");
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = last;
        @(negedge clk);
        check("b_fill_in_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic handoff_b();
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        @(negedge clk);
        check("b_after_handoff_valid", 64'(b_out_valid), 64'd0);
        check("b_after_handoff_data", 64'(b_out_data), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        #2;
        check_empty("reset");
        check("reset_b_in_ready", 64'(b_in_ready), 64'd1);
        check("reset_b_count", 64'(b_out_count), 64'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full frame 0..F, then held 10 cycles with in_valid=1 / data 5 ignored.
        exp_q.push_back('{64'hFEDC_BA98_7654_3210, 16});
        for (int k = 0; k < 16; k++) send(4'(k), 1'b0);
        check_frame(64'hFEDC_BA98_7654_3210, 16);
        in_valid = 1'b1;
        in_data  = 4'h5;
        repeat (10) begin
            @(negedge clk);
            check("hold_data", 64'(out_data), 64'hFEDC_BA98_7654_3210);
            check("hold_count", 64'(out_count), 64'd16);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        handoff();

        // Short frame A,B,C terminated by in_last.
        exp_q.push_back('{64'h0000_0000_0000_0CBA, 3});
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b1);
        check_frame(64'h0000_0000_0000_0CBA, 3);
        handoff();

        // Bubbled stream F..0, slot k = F-k.
        exp_q.push_back('{64'h0123_4567_89AB_CDEF, 16});
        for (int k = 0; k < 16; k++) begin
            idle(int'($urandom_range(0, 2)));
            send(4'(15 - k), 1'b0);
        end
        check_frame(64'h0123_4567_89AB_CDEF, 16);
        handoff();

        // Flush in FILL after 5 words drops the concurrent word 7.
        for (int k = 1; k <= 5; k++) send(4'(k), 1'b0);
        in_valid = 1'b1;
        in_data  = 4'h7;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check_empty("flush_fill");
        @(posedge clk);
        #1;
        exp_q.push_back('{64'h0FED_CBA9_8765_4321, 16});
        for (int k = 0; k < 16; k++) send(4'(k + 1), 1'b0);
        check_frame(64'h0FED_CBA9_8765_4321, 16);
        handoff();

        // Flush in HOLD with out_ready=0 drops the frame (nothing pushed).
        for (int k = 0; k < 16; k++) send(4'(k), 1'b0);
        check_frame(64'hFEDC_BA98_7654_3210, 16);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_empty("flush_hold");
        @(posedge clk);
        #1;

        // Asynchronous reset between edges with idx=9.
        for (int k = 0; k < 9; k++) send(4'(k), 1'b0);
        @(negedge clk);
        check("pre_reset_count", 64'(out_count), 64'd9);
        check("pre_reset_data", 64'(out_data), 64'h0000_0008_7654_3210);
        #2;
        reset = 1'b1;
        #1;
        check_empty("async_reset");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back('{64'h0000_0000_0000_0006, 1});
        send(4'h6, 1'b1);
        check_frame(64'h0000_0000_0000_0006, 1);
        handoff();

        // N=2, WIDTH=8 instance.
        exp_b_q.push_back('{64'h0000_0000_0000_C33C, 2});
        send_b(8'h3C, 1'b0);
        send_b(8'hC3, 1'b0);
        @(negedge clk);
        check("b_full_valid", 64'(b_out_valid), 64'd1);
        check("b_full_in_ready", 64'(b_in_ready), 64'd0);
        check("b_full_count", 64'(b_out_count), 64'd2);
        check("b_full_data", 64'(b_out_data), 64'h0000_0000_0000_C33C);
        @(posedge clk);
        #1;
        handoff_b();
        exp_b_q.push_back('{64'h0000_0000_0000_005A, 1});
        send_b(8'h5A, 1'b1);
        @(negedge clk);
        check("b_short_valid", 64'(b_out_valid), 64'd1);
        check("b_short_count", 64'(b_out_count), 64'd1);
        check("b_short_data", 64'(b_out_data), 64'h0000_0000_0000_005A);
        @(posedge clk);
        #1;
        handoff_b();

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        check("sb_b_drain", 64'(exp_b_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
